// File: rtl/weight_addr_seq.sv
// weight_addr_seq: issues three-channel weight-ROM read addresses for a burst, aligning the registered and combinational ROM channels.
module weight_addr_seq #(
  parameter int ROM_ADDR_BITS = 16,
  parameter int CNT_BITS = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ROM_ADDR_BITS-1:0] base1,
  input  logic [ROM_ADDR_BITS-1:0] base2,
  input  logic [ROM_ADDR_BITS-1:0] base3,
  input  logic [CNT_BITS-1:0]      count,
  input  logic                     stall,
  output logic                     en,
  output logic [ROM_ADDR_BITS-1:0] address1,
  output logic [ROM_ADDR_BITS-1:0] address2,
  output logic [ROM_ADDR_BITS-1:0] address3,
  output logic                     weight_valid,
  output logic                     weight_last,
  output logic                     busy,
  output logic                     done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [CNT_BITS-1:0] idx, cnt;
  logic [ROM_ADDR_BITS-1:0] next3;
  logic issue, fin;
  assign issue = state == RUN && !stall;
  assign fin = idx == cnt - CNT_BITS'(1);
  assign en = issue;
  assign busy = state != IDLE;
  assign done = state == DONE;
  // address1/2 always point at the next beat; address3 trails by one issue to meet the combinational channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      next3 <= '0;
      address1 <= '0;
      address2 <= '0;
      address3 <= '0;
      weight_valid <= 1'b0;
      weight_last <= 1'b0;
    end else begin
      weight_valid <= issue;
      weight_last <= issue && fin;
      unique case (state)
        IDLE: if (start) begin
          address1 <= base1;
          address2 <= base2;
          next3 <= base3;
          cnt <= count;
          idx <= '0;
          state <= count != '0 ? RUN : DONE;
        end
        RUN: if (!stall) begin
          address1 <= address1 + ROM_ADDR_BITS'(1);
          address2 <= address2 + ROM_ADDR_BITS'(1);
          next3 <= next3 + ROM_ADDR_BITS'(1);
          address3 <= next3;
          idx <= idx + CNT_BITS'(1);
          if (fin) state <= DRAIN;
        end
        DRAIN: state <= DONE;
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule
